// File: rtl/bnn_pkg.sv
// Shared types and default sizing for the binary-neuron datapath.
// Imported by bnn_popcount_neuron and by later layers that reuse the popcount.
package bnn_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_BEATS  = 98;
    localparam int DEF_ACC_W  = 10;
    localparam int DEF_CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_AND  = 1'b0,
        MODE_XNOR = 1'b1
    } mode_e;

endpackage : bnn_pkg

// File: rtl/bnn_popcount.sv
// Combinational popcount built as a balanced adder tree by splitting the word
// in halves recursively; a single bit is its own count.
module bnn_popcount #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]           data,
    output logic [$clog2(DATA_W+1)-1:0] count
);

    localparam int OUT_W = $clog2(DATA_W + 1);

    generate
        if (DATA_W == 1) begin : g_leaf
            assign count = data;
        end else begin : g_split
            localparam int LO_N = DATA_W / 2;
            localparam int HI_N = DATA_W - LO_N;
            localparam int LO_W = $clog2(LO_N + 1);
            localparam int HI_W = $clog2(HI_N + 1);

            logic [LO_W-1:0] lo_cnt;
            logic [HI_W-1:0] hi_cnt;

            bnn_popcount #(.DATA_W(LO_N)) u_lo (
                .data  (data[LO_N-1:0]),
                .count (lo_cnt)
            );

            bnn_popcount #(.DATA_W(HI_N)) u_hi (
                .data  (data[DATA_W-1:LO_N]),
                .count (hi_cnt)
            );

            assign count = OUT_W'(lo_cnt) + OUT_W'(hi_cnt);
        end
    endgenerate

endmodule : bnn_popcount

// File: rtl/bnn_popcount_neuron.sv
// Streaming binary neuron: per-beat AND/XNOR + popcount, accumulated over a frame,
// result and threshold fire bit presented on valid/ready. BNN_ACC_SATURATE_EN adds clamping and out_ovf.
module bnn_popcount_neuron
    import bnn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BEATS  = DEF_BEATS,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              mode,
    input  logic [ACC_W-1:0]  threshold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_wgt,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_fire,
`ifdef BNN_ACC_SATURATE_EN
    output logic              out_ovf,
`endif
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int PC_W = $clog2(DATA_W + 1);

    state_e            state, state_n;
    logic [ACC_W-1:0]  acc, acc_n, acc_base, acc_add;
    logic [CNT_W-1:0]  cnt_n;
    mode_e             mode_q, mode_n, mode_eff;
    logic [ACC_W-1:0]  thr_q, thr_n;
    logic              in_ready_q;
    logic [DATA_W-1:0] beat_word;
    logic [PC_W-1:0]   beat_pop;
    logic              accept;
    logic              last_beat;
`ifdef BNN_ACC_SATURATE_EN
    logic              ovf_q, ovf_n;
    logic              clamp;
    logic [ACC_W:0]    sum_ext;
`endif

    // A beat is never taken in a cycle where clear is asserted.
    assign in_ready = in_ready_q & ~clear;
    assign accept   = in_valid & in_ready;

    // The first beat of a frame uses the live mode; later beats use the latched one.
    assign mode_eff  = (state == IDLE) ? mode_e'(mode) : mode_q;
    assign beat_word = (mode_eff == MODE_XNOR) ? ~(in_data ^ in_wgt) : (in_data & in_wgt);

    bnn_popcount #(.DATA_W(DATA_W)) u_popcount (
        .data  (beat_word),
        .count (beat_pop)
    );

    assign acc_base = (state == IDLE) ? '0 : acc;

`ifdef BNN_ACC_SATURATE_EN
    assign sum_ext = {1'b0, acc_base} + (ACC_W + 1)'(beat_pop);
    assign clamp   = sum_ext[ACC_W];
    assign acc_add = clamp ? '1 : sum_ext[ACC_W-1:0];
`else
    assign acc_add = acc_base + ACC_W'(beat_pop);
`endif

    // Frame ends on in_last or on the beat that brings the count to BEATS; both at once end it once.
    assign last_beat = in_last |
                       ((state == IDLE) ? (BEATS == 1) : (beat_cnt == CNT_W'(BEATS - 1)));

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_n = state;
        acc_n   = acc;
        cnt_n   = beat_cnt;
        mode_n  = mode_q;
        thr_n   = thr_q;
`ifdef BNN_ACC_SATURATE_EN
        ovf_n   = ovf_q;
`endif

        if (clear) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
`ifdef BNN_ACC_SATURATE_EN
            ovf_n   = 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    acc_n = '0;
                    cnt_n = '0;
                    if (accept) begin
                        acc_n   = acc_add;
                        cnt_n   = CNT_W'(1);
                        mode_n  = mode_e'(mode);
                        thr_n   = threshold;
                        state_n = last_beat ? DONE : ACCUM;
`ifdef BNN_ACC_SATURATE_EN
                        ovf_n   = clamp;
`endif
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_n = acc_add;
                        cnt_n = beat_cnt + CNT_W'(1);
`ifdef BNN_ACC_SATURATE_EN
                        ovf_n = ovf_q | clamp;
`endif
                        if (last_beat) begin
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_n = IDLE;
                        acc_n   = '0;
                        cnt_n   = '0;
`ifdef BNN_ACC_SATURATE_EN
                        ovf_n   = 1'b0;
`endif
                    end
                end
                default: begin
                    state_n = IDLE;
                    acc_n   = '0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            beat_cnt   <= '0;
            mode_q     <= MODE_AND;
            thr_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef BNN_ACC_SATURATE_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            beat_cnt   <= cnt_n;
            mode_q     <= mode_n;
            thr_q      <= thr_n;
            in_ready_q <= (state_n != DONE);
`ifdef BNN_ACC_SATURATE_EN
            ovf_q      <= ovf_n;
`endif
        end
    end

    // Outputs decode registered state only; acc and thr_q are frozen while DONE waits.
    assign out_valid = (state == DONE);
    assign out_sum   = out_valid ? acc : '0;
    assign out_fire  = out_valid & (acc >= thr_q);
`ifdef BNN_ACC_SATURATE_EN
    assign out_ovf   = ovf_q;
`endif

endmodule : bnn_popcount_neuron

// File: tb/tb_bnn_popcount_neuron.sv
// Self-checking bench for bnn_popcount_neuron: directed frames plus randomized frames
// against a popcount/sum model; three instances cover BEATS=98, BEATS=4 and ACC_W=6.
module tb_bnn_popcount_neuron;

`ifdef BNN_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       mode = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [9:0] thr = '0;
    logic [7:0] data = '0;
    logic [7:0] wgt = '0;
    logic [2:0] ivalid = '0;

    logic [2:0] rdy, ovalid, ofire;
    logic [6:0] bcnt [3];
    logic [9:0] sum0, sum1;
    logic [5:0] sum2;
    logic [2:0] ovf;

    int total = 0;
    int bad   = 0;

    logic [7:0] qd[$];
    logic [7:0] qw[$];
    logic       qmode;
    logic [9:0] qthr;

    always #5 clk = ~clk;

    bnn_popcount_neuron u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .threshold(thr),
        .in_valid(ivalid[0]), .in_ready(rdy[0]), .in_data(data), .in_wgt(wgt), .in_last(in_last),
        .out_valid(ovalid[0]), .out_ready(out_ready), .out_sum(sum0), .out_fire(ofire[0]),
`ifdef BNN_ACC_SATURATE_EN
        .out_ovf(ovf[0]),
`endif
        .beat_cnt(bcnt[0])
    );

    bnn_popcount_neuron #(.BEATS(4)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .threshold(thr),
        .in_valid(ivalid[1]), .in_ready(rdy[1]), .in_data(data), .in_wgt(wgt), .in_last(in_last),
        .out_valid(ovalid[1]), .out_ready(out_ready), .out_sum(sum1), .out_fire(ofire[1]),
`ifdef BNN_ACC_SATURATE_EN
        .out_ovf(ovf[1]),
`endif
        .beat_cnt(bcnt[1])
    );

    bnn_popcount_neuron #(.BEATS(12), .ACC_W(6)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .threshold(thr[5:0]),
        .in_valid(ivalid[2]), .in_ready(rdy[2]), .in_data(data), .in_wgt(wgt), .in_last(in_last),
        .out_valid(ovalid[2]), .out_ready(out_ready), .out_sum(sum2), .out_fire(ofire[2]),
`ifdef BNN_ACC_SATURATE_EN
        .out_ovf(ovf[2]),
`endif
        .beat_cnt(bcnt[2])
    );

`ifndef BNN_ACC_SATURATE_EN
    assign ovf = '0;
`endif

    function automatic logic [31:0] get_sum(input int i);
        case (i)
            0:       return 32'(sum0);
            1:       return 32'(sum1);
            default: return 32'(sum2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: total popcount of the frame, then clamp or wrap to the accumulator width.
    function automatic int model_total();
        int t = 0;
        for (int k = 0; k < qd.size(); k++) begin
            logic [7:0] f;
            f = qmode ? ~(qd[k] ^ qw[k]) : (qd[k] & qw[k]);
            t += $countones(f);
        end
        return t;
    endfunction

    function automatic int model_sum(input int aw);
        int t   = model_total();
        int top = (1 << aw) - 1;
        if (SAT) return (t > top) ? top : t;
        return t % (1 << aw);
    endfunction

    task automatic start_frame(input logic m, input logic [9:0] t);
        qd.delete();
        qw.delete();
        qmode = m;
        qthr  = t;
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!rdy[i] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy[i]) check("in_ready_timeout", 32'(rdy[i]), 32'd1);
    endtask

    task automatic send(input int i, input logic [7:0] d, input logic [7:0] w,
                        input logic m, input logic [9:0] t, input logic last);
        wait_ready(i);
        data      = d;
        wgt       = w;
        mode      = m;
        thr       = t;
        in_last   = last;
        ivalid[i] = 1'b1;
        qd.push_back(d);
        qw.push_back(w);
        @(posedge clk); #1;
        ivalid[i] = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic check_result(input int i, input int aw, input int exp_cnt);
        int n = 0;
        int es;
        int et;
        while (!ovalid[i] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid", 32'(ovalid[i]), 32'd1);
        es = model_sum(aw);
        et = int'(qthr) % (1 << aw);
        check("out_sum", get_sum(i), 32'(es));
        check("out_fire", 32'(ofire[i]), 32'(es >= et));
        check("beat_cnt_done", 32'(bcnt[i]), 32'(exp_cnt));
        check("in_ready_done", 32'(rdy[i]), 32'd0);
        if (SAT) check("out_ovf", 32'(ovf[i]), 32'(model_total() > (1 << aw) - 1));
    endtask

    task automatic release_result(input int i);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(ovalid[i]), 32'd0);
        check("beat_cnt_after_hs", 32'(bcnt[i]), 32'd0);
        check("in_ready_after_hs", 32'(rdy[i]), 32'd1);
        if (SAT) check("out_ovf_after_hs", 32'(ovf[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic m;
        logic [9:0] t;
        logic last;

        // Reset state while rst_n is held low.
        #1;
        check("rst_out_valid", 32'(ovalid[0]), 32'd0);
        check("rst_in_ready", 32'(rdy[0]), 32'd0);
        check("rst_beat_cnt", 32'(bcnt[0]), 32'd0);
        check("rst_out_sum", get_sum(0), 32'd0);
        check("rst_out_fire", 32'(ofire[0]), 32'd0);
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(rdy[0]), 32'd1);

        // AND, BEATS=4, completion by count.
        start_frame(1'b0, 10'd16);
        for (int b = 0; b < 3; b++) send(1, 8'hFF, 8'h0F, 1'b0, 10'd16, 1'b0);
        check("a_not_valid_beat3", 32'(ovalid[1]), 32'd0);
        send(1, 8'hFF, 8'h0F, 1'b0, 10'd16, 1'b0);
        check("a_valid_latency", 32'(ovalid[1]), 32'd1);
        check("a_sum_16", get_sum(1), 32'd16);
        check("a_fire_1", 32'(ofire[1]), 32'd1);
        check_result(1, 10, 4);
        release_result(1);

        // XNOR AA/55 over a full 98-beat frame with no in_last.
        start_frame(1'b1, 10'd5);
        for (int b = 0; b < 97; b++) send(0, 8'hAA, 8'h55, 1'b1, 10'd5, 1'b0);
        check("b_not_valid_beat97", 32'(ovalid[0]), 32'd0);
        check("b_beat_cnt_97", 32'(bcnt[0]), 32'd97);
        send(0, 8'hAA, 8'h55, 1'b1, 10'd5, 1'b0);
        check("b_sum_0", get_sum(0), 32'd0);
        check("b_fire_0", 32'(ofire[0]), 32'd0);
        check_result(0, 10, 98);
        release_result(0);

        // Early end on in_last, then back-pressure with a beat offered.
        start_frame(1'b0, 10'd30);
        send(0, 8'hFF, 8'hFF, 1'b0, 10'd30, 1'b0);
        send(0, 8'hFF, 8'hFF, 1'b0, 10'd30, 1'b0);
        send(0, 8'hFF, 8'hFF, 1'b0, 10'd30, 1'b1);
        check_result(0, 10, 3);
        ivalid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("c_hold_valid", 32'(ovalid[0]), 32'd1);
            check("c_hold_sum", get_sum(0), 32'd24);
            check("c_hold_fire", 32'(ofire[0]), 32'd0);
            check("c_hold_ready", 32'(rdy[0]), 32'd0);
            check("c_hold_cnt", 32'(bcnt[0]), 32'd3);
        end
        ivalid[0] = 1'b0;
        release_result(0);

        // clear on beat 50 with a beat offered.
        start_frame(1'b0, 10'd0);
        for (int b = 0; b < 49; b++)
            send(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 10'd0, 1'b0);
        check("d_beat_cnt_49", 32'(bcnt[0]), 32'd49);
        data = 8'hFF; wgt = 8'hFF; ivalid[0] = 1'b1; clear = 1'b1;
        #1;
        check("d_in_ready_clear", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; ivalid[0] = 1'b0;
        check("d_beat_cnt_cleared", 32'(bcnt[0]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("d_no_out_valid", 32'(ovalid[0]), 32'd0);
            @(posedge clk); #1;
        end
        start_frame(1'b0, 10'd16);
        send(0, 8'hFF, 8'hFF, 1'b0, 10'd16, 1'b0);
        send(0, 8'hFF, 8'hFF, 1'b0, 10'd16, 1'b1);
        check_result(0, 10, 2);
        release_result(0);

        // Asynchronous reset in the middle of a frame.
        start_frame(1'b0, 10'd0);
        for (int b = 0; b < 10; b++) send(0, 8'hFF, 8'hFF, 1'b0, 10'd0, 1'b0);
        check("e_beat_cnt_10", 32'(bcnt[0]), 32'd10);
        #3 rst_n = 1'b0;
        #1;
        check("e_async_cnt", 32'(bcnt[0]), 32'd0);
        check("e_async_ready", 32'(rdy[0]), 32'd0);
        check("e_async_valid", 32'(ovalid[0]), 32'd0);
        check("e_async_sum", get_sum(0), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("e_post_ready", 32'(rdy[0]), 32'd1);
        check("e_post_cnt", 32'(bcnt[0]), 32'd0);
        start_frame(1'b0, 10'd8);
        send(0, 8'hFF, 8'h0F, 1'b0, 10'd8, 1'b0);
        send(0, 8'hFF, 8'h0F, 1'b0, 10'd8, 1'b1);
        check_result(0, 10, 2);
        release_result(0);

        // Accumulator overflow on ACC_W=6: clamp or wrap depending on the build.
        start_frame(1'b0, 10'd20);
        for (int b = 0; b < 10; b++) send(2, 8'hFF, 8'hFF, 1'b0, 10'd20, b == 9);
        check("f_sum_ovf", get_sum(2), SAT ? 32'd63 : 32'd16);
        check_result(2, 6, 10);
        release_result(2);

        // Randomized frames with gaps; mode/threshold change after the first beat must be ignored.
        for (int f = 0; f < 6; f++) begin
            len = (f == 0) ? 98 : (f == 1) ? 1 : int'($urandom_range(1, 98));
            m = 1'($urandom_range(0, 1));
            t = 10'($urandom_range(0, 500));
            start_frame(m, t);
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                last = (b == len - 1) && ((f == 0) || (len < 98) || ($urandom_range(0, 1) == 1));
                send(0, 8'($urandom), 8'($urandom),
                     (b == 0) ? m : 1'($urandom_range(0, 1)),
                     (b == 0) ? t : 10'($urandom_range(0, 1023)), last);
            end
            check_result(0, 10, len);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            release_result(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bnn_popcount_neuron
